// File: rtl/psum_pkg.sv
// psum_pkg: op-code and controller-state encodings shared by the psum scratchpad
package psum_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ACCUM = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add: sign-extend an operand, add it to a stored psum, then saturate or wrap
//   a_i   [DATA_WIDTH]  stored psum (signed)
//   b_i   [IN_WIDTH]    incoming operand (signed)
//   sum_o [DATA_WIDTH]  clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   ovf_o               sum did not fit in DATA_WIDTH
module psum_sat_add #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 20,
    parameter int SATURATE   = 1
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [IN_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  ovf_o
);

    localparam int SW = DATA_WIDTH + 1;

    logic signed [DATA_WIDTH:0]   s;
    logic        [DATA_WIDTH-1:0] max_v;
    logic        [DATA_WIDTH-1:0] min_v;

    assign max_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    assign min_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign s     = $signed({a_i[DATA_WIDTH-1], a_i}) + SW'($signed(b_i));
    // The two top bits of the widened sum disagree exactly when it overflowed
    assign ovf_o = s[DATA_WIDTH] ^ s[DATA_WIDTH-1];
    assign sum_o = (ovf_o && SATURATE != 0) ? (s[DATA_WIDTH] ? min_v : max_v) : s[DATA_WIDTH-1:0];

endmodule

// File: rtl/psum_acc_spad.sv
// psum_acc_spad: partial-sum scratchpad with read/write/accumulate ops and a bulk clear
//   clk, rst                    clock, synchronous active-high reset
//   clr_start / busy            request / progress of zeroing every entry
//   op_valid/op_ready/op_code   op handshake and kind (READ, WRITE, ACCUM, no-op)
//   op_addr, op_data            target entry and signed operand
//   rd_valid, rd_data           READ result, one cycle after issue
//   ovf, addr_err               sticky overflow and out-of-range flags
module psum_acc_spad
    import psum_pkg::*;
#(
    parameter int MEM_DEPTH  = 24,
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  busy,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [IN_WIDTH-1:0]   op_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ovf,
    output logic                  addr_err
);

    state_e                  st_q, st_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    // Pending-write stage: every WRITE/ACCUM lands in memory one cycle after issue,
    // so a WRITE following an ACCUM to the same entry naturally writes last.
    logic                    p_v_q, p_v_d;
    logic                    p_acc_q, p_acc_d;
    logic [ADDR_WIDTH-1:0]   p_addr_q, p_addr_d;
    logic [DATA_WIDTH-1:0]   p_base_q, p_base_d;
    logic [IN_WIDTH-1:0]     p_data_q, p_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    ovf_q, ovf_d;
    logic                    addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   sum, p_val, cur;
    logic                    sum_ovf, fire, addr_ok;

    psum_sat_add #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_add (
        .a_i   (p_base_q),
        .b_i   (p_data_q),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    assign op_ready = st_q == ST_IDLE;
    assign busy     = st_q == ST_CLEAR;
    assign fire     = op_valid && op_ready;
    assign addr_ok  = int'(op_addr) < MEM_DEPTH;
    assign p_val    = p_acc_q ? sum : DATA_WIDTH'($signed(p_data_q));
    // Forward the pending write so the next op sees the newest value of its entry
    assign cur      = (p_v_q && p_addr_q == op_addr) ? p_val : mem[op_addr];

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ovf      = ovf_q;
    assign addr_err = addr_err_q;

    always_comb begin
        st_d       = st_q;
        ptr_d      = ptr_q;
        p_v_d      = 1'b0;
        p_acc_d    = p_acc_q;
        p_addr_d   = p_addr_q;
        p_base_d   = p_base_q;
        p_data_d   = p_data_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q | (p_v_q && p_acc_q && sum_ovf);
        addr_err_d = addr_err_q | (fire && !addr_ok);
        if (st_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                st_d  = ST_IDLE;
                ptr_d = '0;
            end
        end else if (clr_start) begin
            st_d  = ST_CLEAR;
            ptr_d = '0;
        end
        if (fire) begin
            rd_valid_d = op_code == OP_READ;
            rd_data_d  = (op_code == OP_READ) ? (addr_ok ? cur : '0) : rd_data_q;
            p_v_d      = addr_ok && (op_code == OP_WRITE || op_code == OP_ACCUM);
            p_acc_d    = op_code == OP_ACCUM;
            p_addr_d   = op_addr;
            p_base_d   = cur;
            p_data_d   = op_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_CLEAR;
            ptr_q      <= '0;
            p_v_q      <= 1'b0;
            p_acc_q    <= 1'b0;
            p_addr_q   <= '0;
            p_base_q   <= '0;
            p_data_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            ptr_q      <= ptr_d;
            p_v_q      <= p_v_d;
            p_acc_q    <= p_acc_d;
            p_addr_q   <= p_addr_d;
            p_base_q   <= p_base_d;
            p_data_q   <= p_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Single write port: the clear owns it while busy; a pending write arriving then is
    // dropped, which is harmless because the clear zeroes every entry anyway.
    always_ff @(posedge clk) begin
        if (!rst && (busy || p_v_q))
            mem[busy ? ptr_q : p_addr_q] <= busy ? '0 : p_val;
    end

endmodule

// File: tb/tb_psum_acc_spad.sv
// tb_psum_acc_spad: directed checks of the psum scratchpad, saturating and wrapping builds
module tb_psum_acc_spad;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_start = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b11;
    logic [4:0]  op_addr = '0;
    logic [15:0] op_data = '0;
    logic        busy, op_ready, rd_valid, ovf, addr_err;
    logic [19:0] rd_data;
    logic        w_busy, w_op_ready, w_rd_valid, w_ovf, w_addr_err;
    logic [19:0] w_rd_data;
    int          tests = 0;
    int          fails = 0;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, AC = 2'b10;

    psum_acc_spad #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_addr(op_addr), .op_data(op_data), .rd_valid(rd_valid),
        .rd_data(rd_data), .ovf(ovf), .addr_err(addr_err)
    );

    psum_acc_spad #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .clr_start(clr_start), .busy(w_busy),
        .op_valid(op_valid), .op_ready(w_op_ready), .op_code(op_code),
        .op_addr(op_addr), .op_data(op_data), .rd_valid(w_rd_valid),
        .rd_data(w_rd_data), .ovf(w_ovf), .addr_err(w_addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] c, input int a, input int d);
        op_valid = 1'b1;
        op_code  = c;
        op_addr  = 5'(a);
        op_data  = 16'(d);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_clear(input int start, input string name);
        int n;
        n = start;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (n !== 24 || op_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: busy cycles=%0d op_ready=%0b, required 24 and 1", name, n, op_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (busy !== 1'b1 || op_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%0b op_ready=%0b, required 1 0", busy, op_ready);
        end
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 20'd0 || ovf !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rd_valid=%0b rd_data=%0d ovf=%0b addr_err=%0b, required all 0",
                     rd_valid, rd_data, ovf, addr_err);
        end
        rst = 1'b0;
        wait_clear(0, "reset_clear_len");
        for (int i = 0; i < 24; i++) begin
            op(RD, i, 0);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 20'd0) begin
                fails++;
                $display("FAIL reset_read[%0d]: rd_valid=%0b rd_data=%0d, required 1 0", i, rd_valid, rd_data);
            end
        end
    endtask

    task automatic test_accum;
        op(WR, 3, 100);
        op(AC, 3, -30);
        op(AC, 3, 5);
        op(AC, 3, 7);
        op(RD, 3, 0);
        tests++;
        if (rd_valid !== 1'b1 || $signed(rd_data) !== 20'sd82 || $signed(w_rd_data) !== 20'sd82) begin
            fails++;
            $display("FAIL accum_chain: rd_valid=%0b sat=%0d wrap=%0d, required 1 82",
                     rd_valid, $signed(rd_data), $signed(w_rd_data));
        end
        tick();
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 20'd82) begin
            fails++;
            $display("FAIL rd_hold: rd_valid=%0b rd_data=%0d, required 0 82", rd_valid, rd_data);
        end
    endtask

    task automatic test_saturate;
        op(WR, 0, 32767);
        repeat (15) op(AC, 0, 32767);
        op(AC, 0, 15);
        op(RD, 0, 0);
        tests++;
        if (rd_data !== 20'h7FFFF || w_rd_data !== 20'h7FFFF || ovf !== 1'b0 || w_ovf !== 1'b0) begin
            fails++;
            $display("FAIL sat_reach_max: sat=%h wrap=%h ovf=%0b/%0b, required 7ffff 7ffff 0/0",
                     rd_data, w_rd_data, ovf, w_ovf);
        end
        op(AC, 0, 1);
        op(RD, 0, 0);
        tests++;
        if (rd_data !== 20'h7FFFF || ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_pos_clamp: rd_data=%h ovf=%0b, required 7ffff 1", rd_data, ovf);
        end
        tests++;
        if (w_rd_data !== 20'h80000 || w_ovf !== 1'b1) begin
            fails++;
            $display("FAIL wrap_pos: rd_data=%h ovf=%0b, required 80000 1", w_rd_data, w_ovf);
        end
        op(WR, 1, -32768);
        repeat (15) op(AC, 1, -32768);
        op(AC, 1, -1);
        op(RD, 1, 0);
        tests++;
        if (rd_data !== 20'h80000 || w_rd_data !== 20'h7FFFF) begin
            fails++;
            $display("FAIL neg_overflow: sat=%h wrap=%h, required 80000 7ffff", rd_data, w_rd_data);
        end
    endtask

    task automatic test_write_wins;
        op(AC, 5, 10);
        op(WR, 5, 7);
        op(RD, 5, 0);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 20'd7) begin
            fails++;
            $display("FAIL write_wins_fwd: rd_valid=%0b rd_data=%0d, required 1 7", rd_valid, rd_data);
        end
        tick();
        op(RD, 5, 0);
        tests++;
        if (rd_data !== 20'd7) begin
            fails++;
            $display("FAIL write_wins_mem: rd_data=%0d, required 7", rd_data);
        end
    endtask

    task automatic test_addr_err;
        tests++;
        if (addr_err !== 1'b0) begin
            fails++;
            $display("FAIL addr_err_idle: addr_err=%0b, required 0", addr_err);
        end
        op(RD, 30, 0);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 20'd0 || addr_err !== 1'b1) begin
            fails++;
            $display("FAIL addr_err_read: rd_valid=%0b rd_data=%0d addr_err=%0b, required 1 0 1",
                     rd_valid, rd_data, addr_err);
        end
        op(WR, 30, 123);
        op(AC, 24, 5);
        op(RD, 3, 0);
        tests++;
        if (rd_data !== 20'd82) begin
            fails++;
            $display("FAIL addr_err_nomod3: rd_data=%0d, required 82", rd_data);
        end
        op(RD, 5, 0);
        tests++;
        if (rd_data !== 20'd7) begin
            fails++;
            $display("FAIL addr_err_nomod5: rd_data=%0d, required 7", rd_data);
        end
        op(WR, 23, -1);
        op(RD, 23, 0);
        tests++;
        if (rd_data !== 20'hFFFFF) begin
            fails++;
            $display("FAIL last_entry_sext: rd_data=%h, required fffff", rd_data);
        end
    endtask

    task automatic test_clr_start;
        clr_start = 1'b1;
        op(WR, 7, 9);
        tests++;
        if (busy !== 1'b1 || op_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_enter: busy=%0b op_ready=%0b, required 1 0", busy, op_ready);
        end
        tick();
        tick();
        clr_start = 1'b0;
        wait_clear(2, "clr_len");
        for (int i = 0; i < 3; i++) begin
            int a;
            a = (i == 0) ? 3 : (i == 1) ? 7 : 23;
            op(RD, a, 0);
            tests++;
            if (rd_data !== 20'd0) begin
                fails++;
                $display("FAIL clr_zero[%0d]: rd_data=%0d, required 0", a, rd_data);
            end
        end
    endtask

    task automatic test_rst_mid_clear;
        op(WR, 2, 55);
        op(RD, 2, 0);
        tests++;
        if (rd_data !== 20'd55) begin
            fails++;
            $display("FAIL pre_rst_write: rd_data=%0d, required 55", rd_data);
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b1 || ovf !== 1'b0 || addr_err !== 1'b0 || rd_data !== 20'd0) begin
            fails++;
            $display("FAIL mid_clear_rst: busy=%0b ovf=%0b addr_err=%0b rd_data=%0d, required 1 0 0 0",
                     busy, ovf, addr_err, rd_data);
        end
        rst = 1'b0;
        wait_clear(0, "rst_restart_len");
        op(RD, 2, 0);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 20'd0) begin
            fails++;
            $display("FAIL rst_clear_addr2: rd_valid=%0b rd_data=%0d, required 1 0", rd_valid, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_accum();
        test_saturate();
        test_write_wins();
        test_addr_err();
        test_clr_start();
        test_rst_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
